// File: rtl/prefix_adder_6b.sv
// Registered WIDTH-bit Kogge-Stone adder: S = X + Y + c_in, with carry-out in S[WIDTH].
// The carry-in enters the prefix tree as node 0, so the tree spans WIDTH+1 nodes.
module prefix_adder_6b #(
  parameter int WIDTH = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic             c_in,
  input  logic             in_valid,
  output logic [WIDTH:0]   S,
  output logic             out_valid
);

  localparam int LEVELS = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] g_bit;
  logic [WIDTH-1:0] p_bit;
  logic [WIDTH:0]   grp_g;
  logic [WIDTH:1]   grp_p;
  logic [WIDTH:0]   sum_d;
  logic [WIDTH:0]   s_q;
  logic             vld_q;

  assign g_bit = X & Y;
  assign p_bit = X ^ Y;

  // Node j covers operand bit j-1; node 0 is c_in with P=0, so its P is never stored.
  // Each level updates nodes high-to-low so the low partner still holds last level's value.
  // A node whose span reaches node 0 this level (j < 2*dist) gets a gray cell; its P is dead.
  always_comb begin
    grp_g = {g_bit, c_in};
    grp_p = p_bit;
    for (int l = 0; l < LEVELS; l++) begin
      for (int j = WIDTH; j >= (1 << l); j--) begin
        if (j < (2 << l)) begin
          grp_g[j] = grp_g[j] | (grp_p[j] & grp_g[j - (1 << l)]);
          grp_p[j] = 1'b0;
        end else begin
          grp_g[j] = grp_g[j] | (grp_p[j] & grp_g[j - (1 << l)]);
          grp_p[j] = grp_p[j] & grp_p[j - (1 << l)];
        end
      end
    end
  end

  // grp_g[i] is now the carry into bit i; grp_g[WIDTH] is the carry-out.
  assign sum_d = {grp_g[WIDTH], p_bit ^ grp_g[WIDTH-1:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q   <= '0;
      vld_q <= 1'b0;
    end else begin
      s_q   <= sum_d;
      vld_q <= in_valid;
    end
  end

  assign S         = s_q;
  assign out_valid = vld_q;

endmodule

// File: tb/tb_prefix_adder_6b.sv
// Self-checking bench for prefix_adder_6b: reset, directed vectors, exhaustive sweep
// with a mid-stream reset pulse, valid gating and randomized operands.
module tb_prefix_adder_6b;

  localparam int W = 6;

  logic         clk;
  logic         rst_n;
  logic [W-1:0] X;
  logic [W-1:0] Y;
  logic         c_in;
  logic         in_valid;
  logic [W:0]   S;
  logic         out_valid;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         c;
    logic [W:0]   exp_s;
  } vec_t;

  vec_t tbl [5];

  prefix_adder_6b #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .X         (X),
    .Y         (Y),
    .c_in      (c_in),
    .in_valid  (in_valid),
    .S         (S),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ref_sum(input int x, input int y, input int c);
    return x + y + c;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, got, exp);
    end
  endtask

  task automatic check_out(input string name, input int exp_s, input int exp_v);
    chk({name, "_S"}, {25'b0, S}, exp_s);
    chk({name, "_vld"}, {31'b0, out_valid}, exp_v);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [12:0] iv;
    logic [W:0]  held;
    int x, y, c, v;

    tbl[0] = '{x: 6'd0,  y: 6'd0,  c: 1'b0, exp_s: 7'd0};
    tbl[1] = '{x: 6'd63, y: 6'd63, c: 1'b1, exp_s: 7'd127};
    tbl[2] = '{x: 6'd63, y: 6'd0,  c: 1'b1, exp_s: 7'd64};
    tbl[3] = '{x: 6'd21, y: 6'd42, c: 1'b0, exp_s: 7'd63};
    tbl[4] = '{x: 6'd21, y: 6'd42, c: 1'b1, exp_s: 7'd64};

    // Reset dominates a valid maximal operation
    rst_n = 1'b0; X = 6'd63; Y = 6'd63; c_in = 1'b1; in_valid = 1'b1;
    step();
    check_out("reset1", 0, 0);
    step();
    check_out("reset2", 0, 0);
    rst_n = 1'b1;
    step();
    check_out("release", 127, 1);

    // Directed vectors
    for (int k = 0; k < 5; k++) begin
      X = tbl[k].x; Y = tbl[k].y; c_in = tbl[k].c; in_valid = 1'b1;
      step();
      check_out($sformatf("vec%0d", k), int'(tbl[k].exp_s), 1);
    end

    // Output must not follow inputs between edges
    held = S;
    X = ~X; Y = ~Y; c_in = ~c_in;
    #2;
    chk("no_comb_path", {25'b0, S}, {25'b0, held});

    // Exhaustive sweep, one op per cycle, reset pulse at i = 100
    for (int i = 0; i < 8192; i++) begin
      iv = 13'(i);
      {X, Y, c_in} = iv;
      in_valid = 1'b1;
      rst_n = (i != 100);
      step();
      if (i == 100) check_out("sweep_rst100", 0, 0);
      else check_out($sformatf("sweep%0d", i), ref_sum(int'(X), int'(Y), int'(c_in)), 1);
    end
    rst_n = 1'b1;

    // Valid gating: out_valid tracks alternating in_valid, S still carries the sum
    for (int i = 0; i < 40; i++) begin
      X = 6'((i * 7 + 3) % 64); Y = 6'((i * 13 + 5) % 64); c_in = 1'(i % 3 == 0);
      in_valid = 1'(i % 2 == 0);
      step();
      check_out($sformatf("gate%0d", i), ref_sum(int'(X), int'(Y), int'(c_in)), int'(in_valid));
    end

    // Randomized operands and valid
    for (int i = 0; i < 300; i++) begin
      x = int'($urandom_range(0, 63));
      y = int'($urandom_range(0, 63));
      c = int'($urandom_range(0, 1));
      v = int'($urandom_range(0, 1));
      X = 6'(x); Y = 6'(y); c_in = 1'(c); in_valid = 1'(v);
      step();
      check_out($sformatf("rand%0d", i), ref_sum(x, y, c), v);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
